// File: rtl/bus_resp_regfile_if.sv
// bus_resp_regfile_if: request/response bus between a master and a wait-state responder
// req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb carry requests from the master.
// rsp_valid/rsp_ready/rsp_rdata/rsp_err carry the response back.
interface bus_resp_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bus_resp_regfile.sv
// bus_resp_regfile: bus responder with a byte-strobed register file and programmable wait states
// clk   : rising-edge clock
// reset : asynchronous active-low reset, clears all state and registers
// bus   : slave side of bus_resp_regfile_if (request in, one response out per request)
module bus_resp_regfile #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  bus_resp_regfile_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [7:0]        cnt;
  logic              l_write;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [NB-1:0]     l_wstrb;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [NB-1:0]     c_wstrb;
  logic              c_err;
  logic [IW-1:0]     c_idx;
  logic              fire;
  // With zero wait states the response is formed on the accept edge itself,
  // so the request fields come straight from the bus while IDLE.
  always_comb begin
    c_write = state == IDLE ? bus.req_write : l_write;
    c_addr  = state == IDLE ? bus.req_addr  : l_addr;
    c_wdata = state == IDLE ? bus.req_wdata : l_wdata;
    c_wstrb = state == IDLE ? bus.req_wstrb : l_wstrb;
    c_err   = 32'(c_addr) >= 32'(NUM_REGS);
    c_idx   = c_addr[IW-1:0];
    fire    = state == IDLE ? bus.req_valid && WAIT_CYCLES == 0 : state == WAIT && cnt == 8'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      l_write     <= 1'b0;
      l_addr      <= '0;
      l_wdata     <= '0;
      l_wstrb     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (fire) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= c_err;
        rsp_rdata_q <= (!c_write && !c_err) ? regs[c_idx] : '0;
        if (c_write && !c_err)
          for (int i = 0; i < NB; i++)
            if (c_wstrb[i]) regs[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
      case (state)
        IDLE: if (bus.req_valid) begin
          l_write <= bus.req_write;
          l_addr  <= bus.req_addr;
          l_wdata <= bus.req_wdata;
          l_wstrb <= bus.req_wstrb;
          cnt     <= 8'(WAIT_CYCLES);
          state   <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_bus_resp_regfile.sv
// tb_bus_resp_regfile: directed checks of bus_resp_regfile with 2 and 0 wait states
module tb_bus_resp_regfile;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  bus_resp_regfile_if #(.DATA_W(32), .ADDR_W(8)) b2 ();
  bus_resp_regfile_if #(.DATA_W(32), .ADDR_W(8)) b0 ();
  bus_resp_regfile #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(16), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .bus(b2));
  bus_resp_regfile #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(16), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic issue(input bit sel, input string tag, input bit w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    check({tag, "_req_ready"}, sel ? b0.req_ready : b2.req_ready, 1);
    if (sel) begin
      b0.req_valid = 1'b1; b0.req_write = w; b0.req_addr = a; b0.req_wdata = d; b0.req_wstrb = s;
    end else begin
      b2.req_valid = 1'b1; b2.req_write = w; b2.req_addr = a; b2.req_wdata = d; b2.req_wstrb = s;
    end
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    b2.req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input bit sel, input string tag, input int exp_lat);
    int lat = 0;
    while (!(sel ? b0.rsp_valid : b2.rsp_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask
  task automatic finish_rsp(input bit sel, input string tag, input logic [31:0] exp_rdata,
                            input logic exp_err);
    check({tag, "_rdata"}, sel ? b0.rsp_rdata : b2.rsp_rdata, exp_rdata);
    check({tag, "_err"}, sel ? b0.rsp_err : b2.rsp_err, exp_err);
    if (sel) b0.rsp_ready = 1'b1; else b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b0.rsp_ready = 1'b0;
    b2.rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, sel ? b0.rsp_valid : b2.rsp_valid, 0);
  endtask
  task automatic do_req(input bit sel, input string tag, input bit w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rdata, input logic exp_err);
    issue(sel, tag, w, a, d, s);
    wait_rsp(sel, tag, sel ? 0 : 2);
    finish_rsp(sel, tag, exp_rdata, exp_err);
  endtask
  initial begin
    reset = 1'b0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b2.req_wstrb = '0; b2.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.req_wstrb = '0; b0.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_req_ready", b2.req_ready, 1);
    check("rst_rsp_valid", b2.rsp_valid, 0);
    check("rst_rsp_rdata", b2.rsp_rdata, 0);
    check("rst_rsp_err", b2.rsp_err, 0);
    do_req(0, "rd5", 0, 8'd5, 0, 0, 32'h0, 0);
    do_req(0, "wr3", 1, 8'd3, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    do_req(0, "rd3", 0, 8'd3, 0, 0, 32'hDEADBEEF, 0);
    do_req(0, "wr7", 1, 8'd7, 32'h11223344, 4'hF, 32'h0, 0);
    do_req(0, "wr7_strb", 1, 8'd7, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
    do_req(0, "rd7", 0, 8'd7, 0, 0, 32'h11BB33DD, 0);
    do_req(0, "wr7_zero_strb", 1, 8'd7, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    do_req(0, "rd7_after_zero", 0, 8'd7, 0, 0, 32'h11BB33DD, 0);
    do_req(0, "wr16", 1, 8'd16, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    do_req(0, "rd16", 0, 8'd16, 0, 0, 32'h0, 1);
    do_req(0, "rd255", 0, 8'd255, 0, 0, 32'h0, 1);
    for (int i = 0; i < 16; i++)
      do_req(0, $sformatf("reg%0d", i), 0, 8'(i), 0, 0,
             i == 3 ? 32'hDEADBEEF : i == 7 ? 32'h11BB33DD : 32'h0, 0);
    issue(0, "bp", 0, 8'd3, 0, 0);
    wait_rsp(0, "bp", 2);
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 8'd3;
    b2.req_wdata = 32'h0; b2.req_wstrb = 4'hF;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", b2.rsp_valid, 1);
      check("bp_rsp_rdata", b2.rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", b2.req_ready, 0);
    end
    b2.req_valid = 1'b0;
    finish_rsp(0, "bp", 32'hDEADBEEF, 0);
    do_req(0, "rd3_after_bp", 0, 8'd3, 0, 0, 32'hDEADBEEF, 0);
    issue(0, "wr2_abort", 1, 8'd2, 32'h12345678, 4'hF);
    check("wait_req_ready", b2.req_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_wait_valid", b2.rsp_valid, 0);
    check("rst_wait_ready", b2.req_ready, 1);
    @(posedge clk); #1 reset = 1'b1;
    do_req(0, "rd2_after_rst", 0, 8'd2, 0, 0, 32'h0, 0);
    do_req(0, "rd3_after_rst", 0, 8'd3, 0, 0, 32'h0, 0);
    do_req(0, "wr5", 1, 8'd5, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
    issue(0, "rd5_drop", 0, 8'd5, 0, 0);
    wait_rsp(0, "rd5_drop", 2);
    check("resp_rdata_pre_rst", b2.rsp_rdata, 32'hA5A5A5A5);
    reset = 1'b0;
    #1;
    check("rst_resp_valid", b2.rsp_valid, 0);
    check("rst_resp_rdata", b2.rsp_rdata, 0);
    @(posedge clk); #1 reset = 1'b1;
    check("rst_resp_req_ready", b2.req_ready, 1);
    do_req(1, "w0_wr4", 1, 8'd4, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    do_req(1, "w0_rd4", 0, 8'd4, 0, 0, 32'hCAFEF00D, 0);
    do_req(1, "w0_wr4_hi", 1, 8'd4, 32'h00990000, 4'b1100, 32'h0, 0);
    do_req(1, "w0_rd4_hi", 0, 8'd4, 0, 0, 32'h0099F00D, 0);
    do_req(1, "w0_rd20", 0, 8'd20, 0, 0, 32'h0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
